parallel_block_dispatcher: RTL and testbench

Parametrised successor to the fixed-grid parallel block looper. Walks a VDIM-dimensional block grid and dispatches block offsets to N_LANE tau lanes. Per-lane pending-block credit limits outstanding work. Supports a static mode (block k to lane k mod N_LANE) and a dynamic mode (next block to the first available lane, round-robin). Sits between the config front-end and the tau array; acks the config only after every dispatched block reports done.

---
 rtl/parallel_block_dispatcher_if.sv | 31 +++
 rtl/parallel_block_dispatcher.sv | 195 +++++++++++++++++++
 tb/tb_parallel_block_dispatcher.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parallel_block_dispatcher_if.sv
// Config and lane-side bundle for parallel_block_dispatcher.
// The dispatcher uses the slave modport; the config front-end and tau array use master.
interface parallel_block_dispatcher_if #(
  parameter int WBW    = 16,
  parameter int VDIM   = 3,
  parameter int N_LANE = 4,
  parameter int CNT_BW = 16
);
  logic                                 src_rdy;
  logic                                 src_ack;
  logic [VDIM-1:0][WBW-1:0]             i_bgrid_step;
  logic [VDIM-1:0][WBW-1:0]             i_bgrid_end;
  logic [VDIM-1:0][WBW-1:0]             i_bboundary;
  logic                                 i_mode;
  logic [N_LANE-1:0]                    bofs_rdys;
  logic [N_LANE-1:0]                    bofs_acks;
  logic [N_LANE-1:0][VDIM-1:0][WBW-1:0] o_bofss;
  logic [N_LANE-1:0]                    blkdone_dvals;
  logic [CNT_BW-1:0]                    o_n_issued;
  logic                                 o_busy;

  modport slave (
    input  src_rdy, i_bgrid_step, i_bgrid_end, i_bboundary, i_mode, bofs_acks, blkdone_dvals,
    output src_ack, bofs_rdys, o_bofss, o_n_issued, o_busy
  );

  modport master (
    output src_rdy, i_bgrid_step, i_bgrid_end, i_bboundary, i_mode, bofs_acks, blkdone_dvals,
    input  src_ack, bofs_rdys, o_bofss, o_n_issued, o_busy
  );
endinterface

// File: rtl/parallel_block_dispatcher.sv
// Walks a VDIM-dimensional block grid and hands block offsets to N_LANE tau lanes,
// bounded by a per-lane credit of outstanding blocks; acks the config once all blocks are done.
module parallel_block_dispatcher #(
  parameter int WBW       = 16,
  parameter int VDIM      = 3,
  parameter int N_LANE    = 4,
  parameter int N_PENDING = 2,
  parameter int CNT_BW    = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  parallel_block_dispatcher_if.slave bus
);

  localparam int PTR_W = (N_LANE > 1) ? $clog2(N_LANE) : 1;
  localparam int CR_W  = $clog2(N_PENDING + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  typedef logic [VDIM-1:0][WBW-1:0] coord_t;

  state_t                   r_state, w_next_state;
  coord_t                   r_step, r_end, r_bnd, r_cursor;
  logic                     r_mode;
  logic [PTR_W-1:0]         r_ptr;
  logic [N_LANE-1:0]        r_rdy;
  logic [N_LANE-1:0][VDIM-1:0][WBW-1:0] r_bofs;
  logic [N_LANE-1:0][CR_W-1:0] r_credit;
  logic [CNT_BW-1:0]        r_n_issued;

  logic                     w_start, w_empty, w_valid, w_last, w_adv, w_drained;
  coord_t                   w_next_cursor;
  logic [PTR_W-1:0]         w_next_ptr, w_idx;
  logic [N_LANE-1:0]        w_avail, w_grant, w_fire;
  logic [CNT_BW-1:0]        w_fire_cnt;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_LANE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_start   = (r_state == S_IDLE) && bus.src_rdy;
  assign w_fire    = r_rdy & bus.bofs_acks;
  assign w_drained = (r_rdy == '0) && (r_credit == '0);

  always_comb begin
    w_empty = 1'b0;
    w_valid = 1'b1;
    for (int d = 0; d < VDIM; d++) begin
      if (r_end[d] == '0) w_empty = 1'b1;
      if (r_cursor[d] >= r_bnd[d]) w_valid = 1'b0;
    end
  end

  always_comb begin
    for (int l = 0; l < N_LANE; l++) begin
      w_avail[l] = !r_rdy[l] && (r_credit[l] < CR_W'(N_PENDING));
    end
  end

  // Odometer step: the fastest dim absorbs the step, wrapping dims carry downward.
  // The sum is one bit wider so a WBW overflow still reads as past the end.
  always_comb begin
    logic         carry;
    logic [WBW:0] sum;
    w_next_cursor = r_cursor;
    carry         = 1'b1;
    sum           = '0;
    for (int d = VDIM - 1; d >= 0; d--) begin
      sum = {1'b0, r_cursor[d]} + {1'b0, r_step[d]};
      if (carry) begin
        if (sum >= {1'b0, r_end[d]}) begin
          w_next_cursor[d] = '0;
        end else begin
          w_next_cursor[d] = sum[WBW-1:0];
          carry            = 1'b0;
        end
      end
    end
    w_last = carry;
  end

  // Static mode ties block k to lane k mod N_LANE, so invalid blocks still consume a ptr slot.
  always_comb begin
    w_grant    = '0;
    w_adv      = 1'b0;
    w_next_ptr = r_ptr;
    w_idx      = '0;
    if (r_state == S_RUN && !w_empty) begin
      if (!w_valid) begin
        w_adv = 1'b1;
        if (!r_mode) w_next_ptr = ptrInc(r_ptr);
      end else if (!r_mode) begin
        if (w_avail[r_ptr]) begin
          w_grant[r_ptr] = 1'b1;
          w_adv          = 1'b1;
          w_next_ptr     = ptrInc(r_ptr);
        end
      end else begin
        for (int i = 0; i < N_LANE; i++) begin
          w_idx = (int'(r_ptr) + i >= N_LANE) ? PTR_W'(int'(r_ptr) + i - N_LANE)
                                              : PTR_W'(int'(r_ptr) + i);
          if (!w_adv && w_avail[w_idx]) begin
            w_grant[w_idx] = 1'b1;
            w_adv          = 1'b1;
            w_next_ptr     = ptrInc(w_idx);
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.src_rdy) w_next_state = S_RUN;
      S_RUN:   if (w_empty || (w_adv && w_last)) w_next_state = S_DRAIN;
      S_DRAIN: if (w_drained) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.src_ack = (r_state == S_DRAIN) && w_drained;
    bus.o_busy  = (r_state != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_step   <= '0;
      r_end    <= '0;
      r_bnd    <= '0;
      r_mode   <= 1'b0;
      r_cursor <= '0;
      r_ptr    <= '0;
      r_rdy    <= '0;
      r_bofs   <= '0;
    end else begin
      if (w_start) begin
        r_step   <= bus.i_bgrid_step;
        r_end    <= bus.i_bgrid_end;
        r_bnd    <= bus.i_bboundary;
        r_mode   <= bus.i_mode;
        r_cursor <= '0;
        r_ptr    <= '0;
      end else if (w_adv) begin
        r_cursor <= w_next_cursor;
        r_ptr    <= w_next_ptr;
      end
      for (int l = 0; l < N_LANE; l++) begin
        if (w_grant[l]) begin
          r_bofs[l] <= r_cursor;
          r_rdy[l]  <= 1'b1;
        end else if (w_fire[l]) begin
          r_rdy[l]  <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_fire_cnt = '0;
    for (int l = 0; l < N_LANE; l++) begin
      w_fire_cnt = w_fire_cnt + CNT_BW'(w_fire[l]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_credit   <= '0;
      r_n_issued <= '0;
    end else begin
      for (int l = 0; l < N_LANE; l++) begin
        if (w_fire[l] && !bus.blkdone_dvals[l]) r_credit[l] <= r_credit[l] + CR_W'(1);
        else if (!w_fire[l] && bus.blkdone_dvals[l]) r_credit[l] <= r_credit[l] - CR_W'(1);
      end
      if (w_start) r_n_issued <= '0;
      else         r_n_issued <= r_n_issued + w_fire_cnt;
    end
  end

  assign bus.bofs_rdys  = r_rdy;
  assign bus.o_bofss    = r_bofs;
  assign bus.o_n_issued = r_n_issued;

  // A lane may only report done for a block it actually holds.
  for (genvar g = 0; g < N_LANE; g++) begin : g_done_chk
    a_done_with_credit: assert property (@(posedge i_clk) disable iff (!i_rst)
      !(bus.blkdone_dvals[g] && (r_credit[g] == '0)));
  end

endmodule

// File: tb/tb_parallel_block_dispatcher.sv
// Scoreboard bench for parallel_block_dispatcher: directed grids, per-lane expected offsets,
// a tau-lane model that reports done a few cycles after each accepted offset.
module tb_parallel_block_dispatcher;

  localparam int WBW       = 16;
  localparam int VDIM      = 2;
  localparam int N_LANE    = 4;
  localparam int N_PENDING = 2;
  localparam int CNT_BW    = 16;

  typedef logic [VDIM-1:0][WBW-1:0] coord_t;
  typedef struct { int lane; coord_t ofs; } exp_t;
  typedef struct { int lane; int due; } done_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N_LANE-1:0] doneDrv = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int srcCyc = 0;
  int lastDoneCyc = 0;
  int ackArmed = 0;
  int ackCount = 0;
  int forceReq0 = 0;
  int forceTaken0 = 0;
  bit ackAfterStart = 1'b0;
  bit autoDone = 1'b1;
  int u;

  exp_t  expQ[$];
  done_t doneQ[$];

  parallel_block_dispatcher_if #(.WBW(WBW), .VDIM(VDIM), .N_LANE(N_LANE), .CNT_BW(CNT_BW)) bus ();

  parallel_block_dispatcher #(
    .WBW(WBW), .VDIM(VDIM), .N_LANE(N_LANE), .N_PENDING(N_PENDING), .CNT_BW(CNT_BW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  assign bus.blkdone_dvals = doneDrv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic coord_t mk(input int a, input int b);
    coord_t r;
    r[0] = WBW'(a);
    r[1] = WBW'(b);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic expectBlock(input int lane, input int c0, input int c1);
    expQ.push_back('{lane, mk(c0, c1)});
  endtask

  task automatic applyStimulus(input int s0, input int s1, input int e0, input int e1,
                               input int b0, input int b1, input bit mode, input bit fromStart);
    @(posedge clk); #1;
    bus.i_bgrid_step = mk(s0, s1);
    bus.i_bgrid_end  = mk(e0, e1);
    bus.i_bboundary  = mk(b0, b1);
    bus.i_mode       = mode;
    ackAfterStart    = fromStart;
    srcCyc           = cyc;
    ackArmed++;
    bus.src_rdy      = 1'b1;
    @(posedge clk); #1;
    bus.src_rdy      = 1'b0;
  endtask

  task automatic waitAck(input int budget);
    int start;
    bit got;
    start = ackCount;
    got   = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (ackCount != start) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL src_ack_timeout got=none required=pulse");
    end
  endtask

  // Monitor: pops the expected offset for every lane handshake and checks src_ack timing.
  always @(negedge clk) begin
    int hit;
    if (!rst_n) begin
      expQ.delete();
      ackCount = ackArmed;
    end else begin
      for (int l = 0; l < N_LANE; l++) begin
        if (bus.bofs_rdys[l] && bus.bofs_acks[l]) begin
          hit = -1;
          for (int k = 0; k < expQ.size(); k++) begin
            if (hit < 0 && expQ[k].lane == l) hit = k;
          end
          if (hit < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL lane%0d_unexpected got=%0h required=none", l, bus.o_bofss[l]);
          end else begin
            checkOutput($sformatf("lane%0d_bofs", l), bus.o_bofss[l], expQ[hit].ofs);
            expQ.delete(hit);
          end
          doneQ.push_back('{l, cyc + 3});
        end
      end
      if (bus.src_ack) begin
        if (ackArmed == ackCount) begin
          checks++;
          failures++;
          $display("[TB] FAIL src_ack_unexpected got=1 required=0");
        end else begin
          checkOutput("src_ack_cycle", cyc, ackAfterStart ? srcCyc + 2 : lastDoneCyc + 1);
          checkOutput("blocks_outstanding", expQ.size(), 0);
          ackCount++;
        end
      end
    end
  end

  // Tau-lane model: one done pulse per lane per cycle, once the block's due cycle is reached.
  always @(posedge clk) begin
    bit fire;
    #1;
    if (!rst_n) begin
      doneQ.delete();
      doneDrv = '0;
    end else begin
      for (int l = 0; l < N_LANE; l++) begin
        fire = 1'b0;
        if (autoDone || (l == 0 && forceReq0 != forceTaken0)) begin
          for (int k = 0; k < doneQ.size(); k++) begin
            if (!fire && doneQ[k].lane == l && doneQ[k].due <= cyc) begin
              fire = 1'b1;
              doneQ.delete(k);
            end
          end
        end
        doneDrv[l] = fire;
        if (fire) begin
          lastDoneCyc = cyc;
          if (l == 0 && forceReq0 != forceTaken0) forceTaken0++;
        end
      end
    end
  end

  task automatic runBasicStatic();
    bus.bofs_acks = '1;
    for (int k = 0; k < 6; k++) expectBlock(k % 4, k / 3, k % 3);
    applyStimulus(1, 1, 2, 3, 2, 3, 1'b0, 1'b0);
  endtask

  initial begin
    bus.src_rdy      = 1'b0;
    bus.i_bgrid_step = '0;
    bus.i_bgrid_end  = '0;
    bus.i_bboundary  = '0;
    bus.i_mode       = 1'b0;
    bus.bofs_acks    = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_bofs_rdys", bus.bofs_rdys, 0);
    checkOutput("rst_bofss", bus.o_bofss, 0);
    checkOutput("rst_n_issued", bus.o_n_issued, 0);
    checkOutput("rst_busy", bus.o_busy, 0);
    checkOutput("rst_src_ack", bus.src_ack, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] static 2x3 grid");
    runBasicStatic();
    @(negedge clk);
    checkOutput("first_rdy_t1", bus.bofs_rdys, 4'b0000);
    @(negedge clk);
    checkOutput("first_rdy_t2", bus.bofs_rdys, 4'b0001);
    waitAck(200);
    checkOutput("static_n_issued", bus.o_n_issued, 6);
    checkOutput("static_busy_after", bus.o_busy, 0);

    $display("[TB] boundary skip");
    expectBlock(0, 0, 0);
    expectBlock(1, 0, 2);
    applyStimulus(1, 2, 2, 4, 1, 3, 1'b0, 1'b0);
    waitAck(200);
    checkOutput("bound_n_issued", bus.o_n_issued, 2);

    $display("[TB] dynamic with lane1 stalled");
    bus.bofs_acks = 4'b1101;
    expectBlock(0, 0, 0);
    expectBlock(1, 0, 1);
    expectBlock(2, 0, 2);
    expectBlock(3, 1, 0);
    expectBlock(0, 1, 1);
    expectBlock(2, 1, 2);
    applyStimulus(1, 1, 2, 3, 2, 3, 1'b1, 1'b0);
    repeat (15) @(negedge clk);
    checkOutput("dyn_l1_held", bus.bofs_rdys[1], 1);
    checkOutput("dyn_l1_bofs", bus.o_bofss[1], mk(0, 1));
    checkOutput("dyn_busy", bus.o_busy, 1);
    @(posedge clk); #1;
    bus.bofs_acks = '1;
    waitAck(200);
    checkOutput("dyn_n_issued", bus.o_n_issued, 6);

    $display("[TB] credit limit");
    autoDone = 1'b0;
    for (int k = 0; k < 12; k++) expectBlock(k % 4, k / 4, k % 4);
    applyStimulus(1, 1, 3, 4, 3, 4, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("credit_n_issued", bus.o_n_issued, 8);
    checkOutput("credit_stall_rdys", bus.bofs_rdys, 0);
    checkOutput("credit_busy", bus.o_busy, 1);
    forceReq0++;
    @(negedge clk);
    u = lastDoneCyc;
    checkOutput("force_done_cycle", cyc, u);
    @(negedge clk);
    checkOutput("credit_rel_t1", bus.bofs_rdys[0], 0);
    @(negedge clk);
    checkOutput("credit_rel_t2", bus.bofs_rdys[0], 1);
    checkOutput("credit_rel_bofs", bus.o_bofss[0], mk(2, 0));
    autoDone = 1'b1;
    waitAck(400);
    checkOutput("credit_total", bus.o_n_issued, 12);

    $display("[TB] empty grid");
    applyStimulus(1, 1, 0, 3, 2, 3, 1'b0, 1'b1);
    waitAck(20);
    checkOutput("empty_n_issued", bus.o_n_issued, 0);
    checkOutput("empty_rdys", bus.bofs_rdys, 0);

    $display("[TB] reset mid-run");
    autoDone = 1'b0;
    runBasicStatic();
    repeat (4) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_rdys", bus.bofs_rdys, 0);
    checkOutput("midrst_bofss", bus.o_bofss, 0);
    checkOutput("midrst_n_issued", bus.o_n_issued, 0);
    checkOutput("midrst_busy", bus.o_busy, 0);
    checkOutput("midrst_src_ack", bus.src_ack, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    autoDone = 1'b1;
    runBasicStatic();
    waitAck(200);
    checkOutput("rerun_n_issued", bus.o_n_issued, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
